// File: rtl/fire_ofm_writer_if.sv
// ============================================================================
// fire_ofm_writer_if : layer-output capture and activation-RAM write bundle
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fire_ofm_writer_if #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 256,
  parameter int LANES  = 8,
  parameter int WOUT   = 16
);
  localparam int GROUPS = DSP_NO / LANES;
  localparam int AW     = $clog2(WOUT * WOUT * GROUPS);

  logic [WIDTH-1:0]       ofm [0:DSP_NO-1];
  logic                   sample;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [LANES*WIDTH-1:0] wr_data;
  logic                   ram_feedback;
  logic                   overflow;
  logic                   busy;

  modport master (
    output ofm, sample,
    input  wr_en, wr_addr, wr_data, ram_feedback, overflow, busy
  );

  modport slave (
    input  ofm, sample,
    output wr_en, wr_addr, wr_data, ram_feedback, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/fire_ofm_writer.sv
// ============================================================================
// fire_ofm_writer : ping-pong capture of a layer's ofm vector, drained to the
//                   activation RAM LANES words per cycle.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fire_ofm_writer #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 256,
  parameter int LANES  = 8,
  parameter int WOUT   = 16
) (
  input  wire                  clk,
  input  wire                  rst,
  fire_ofm_writer_if.slave     bus
);

  localparam int GROUPS = DSP_NO / LANES;
  localparam int NPOS   = WOUT * WOUT;
  localparam int AW     = $clog2(NPOS * GROUPS);
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int TW     = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int PW     = $clog2(NPOS + 1);
  localparam int CW     = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [WIDTH-1:0]       r_buf [0:1][0:DSP_NO-1];
  logic [1:0]             r_full;
  logic [TW-1:0]          r_tag [0:1];
  logic                   r_wr_sel;
  logic                   r_rd_sel;
  logic [PW-1:0]          r_pos_cap;
  logic [PW-1:0]          r_pos_wr;
  logic [GW-1:0]          r_grp;

  logic                   r_wr_en;
  logic [AW-1:0]          r_wr_addr;
  logic [LANES*WIDTH-1:0] r_wr_data;
  logic                   r_ram_feedback;
  logic                   r_overflow;

  logic                   w_issue;
  logic                   w_last;
  logic                   w_free;
  logic                   w_open;
  logic                   w_accept;
  logic                   w_drop;
  logic [CW-1:0]          w_base;
  logic [AW-1:0]          w_addr;
  logic [LANES*WIDTH-1:0] w_data;

  // IDLE issues group 0 on the same edge it leaves, so a buffer filled at
  // edge t has its first word registered at edge t+1.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_sel]) begin
          w_issue     = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: w_issue = 1'b1;
      S_DONE:  w_issue = 1'b0;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_issue && (r_grp == GW'(GROUPS - 1))) begin
      w_last = 1'b1;
      if (r_pos_wr == PW'(NPOS - 1))
        w_state_nxt = S_DONE;
      else if (r_full[~r_rd_sel])
        w_state_nxt = S_DRAIN;
      else
        w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Fill and drain both alternate A/B, so the only candidate is r_wr_sel;
  // it also counts as free when its last group leaves on this edge.
  assign w_free   = !r_full[r_wr_sel] || (w_last && (r_rd_sel == r_wr_sel));
  assign w_open   = bus.sample && (r_state != S_DONE) && (r_pos_cap < PW'(NPOS));
  assign w_accept = w_open && w_free;
  assign w_drop   = w_open && !w_free;

  assign w_base = CW'(r_grp) * CW'(LANES);
  assign w_addr = AW'(r_tag[r_rd_sel]) * AW'(GROUPS) + AW'(r_grp);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_data[l*WIDTH +: WIDTH] = r_buf[r_rd_sel][w_base + CW'(l)];
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr_sel] <= bus.ofm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full         <= '0;
      r_tag[0]       <= '0;
      r_tag[1]       <= '0;
      r_wr_sel       <= 1'b0;
      r_rd_sel       <= 1'b0;
      r_pos_cap      <= '0;
      r_pos_wr       <= '0;
      r_grp          <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_ram_feedback <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_wr_en <= w_issue;
      if (w_issue) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
        r_grp     <= w_last ? '0 : r_grp + 1'b1;
      end
      if (w_last) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
        r_pos_wr         <= r_pos_wr + 1'b1;
      end
      // Placed after the release so a same-edge refill of that buffer wins.
      if (w_accept) begin
        r_full[r_wr_sel] <= 1'b1;
        r_tag[r_wr_sel]  <= r_pos_cap[TW-1:0];
        r_wr_sel         <= ~r_wr_sel;
        r_pos_cap        <= r_pos_cap + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (r_state == S_DONE) r_ram_feedback <= 1'b1;
    end
  end

  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.ram_feedback = r_ram_feedback;
  assign bus.overflow     = r_overflow;
  assign bus.busy         = (|r_full) || (r_state == S_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_fire_ofm_writer.sv
// ============================================================================
// tb_fire_ofm_writer : directed vector bench for fire_ofm_writer
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fire_ofm_writer;

  localparam int WIDTH  = 16;
  localparam int DSP_NO = 256;
  localparam int LANES  = 8;
  localparam int WOUT   = 16;
  localparam int GROUPS = DSP_NO / LANES;
  localparam int NPOS   = WOUT * WOUT;
  localparam int NWR    = NPOS * GROUPS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fire_ofm_writer_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .LANES(LANES), .WOUT(WOUT)) ifc ();

  fire_ofm_writer #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .LANES(LANES), .WOUT(WOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_err    = 0;
  int exp_addr = 0;
  int n_writes = 0;

  typedef struct {
    int          cyc;
    logic        en;
    int          addr;
    logic [15:0] l0;
    logic [15:0] l7;
    logic        busy;
  } vec_t;

  vec_t vt [0:5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ofm[i] = pos*DSP_NO + i makes every written word equal addr*LANES + lane.
  function automatic logic [127:0] model(input int a);
    logic [127:0] m;
    m = '0;
    for (int l = 0; l < LANES; l++) m[l*WIDTH +: WIDTH] = 16'(a * LANES + l);
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst && ifc.wr_en === 1'b1) begin
      chk("wr_addr", 128'(ifc.wr_addr), 128'(exp_addr));
      chk("wr_data", ifc.wr_data, model(exp_addr));
      if (exp_addr == NWR - 1) chk("rf_early", 128'(ifc.ram_feedback), 128'(0));
      exp_addr++;
      n_writes++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ofm(input int pos);
    for (int i = 0; i < DSP_NO; i++) ifc.ofm[i] = 16'(pos * DSP_NO + i);
  endtask

  task automatic do_sample(input int pos);
    set_ofm(pos);
    ifc.sample = 1'b1;
    step(1);
    ifc.sample = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst      = 1'b0;
    exp_addr = 0;
    n_writes = 0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000 && (ifc.busy || ifc.wr_en); k++) step(1);
    chk("idle_timeout", 128'(ifc.busy | ifc.wr_en), 128'(0));
  endtask

  initial begin
    int cur;
    int cnt;

    ifc.sample = 1'b0;
    set_ofm(0);

    vt[0] = '{cyc: 0,  en: 1'b0, addr: 0,  l0: 16'd0,   l7: 16'd0,   busy: 1'b1};
    vt[1] = '{cyc: 1,  en: 1'b1, addr: 0,  l0: 16'd0,   l7: 16'd7,   busy: 1'b1};
    vt[2] = '{cyc: 2,  en: 1'b1, addr: 1,  l0: 16'd8,   l7: 16'd15,  busy: 1'b1};
    vt[3] = '{cyc: 16, en: 1'b1, addr: 15, l0: 16'd120, l7: 16'd127, busy: 1'b1};
    vt[4] = '{cyc: 32, en: 1'b1, addr: 31, l0: 16'd248, l7: 16'd255, busy: 1'b0};
    vt[5] = '{cyc: 33, en: 1'b0, addr: 31, l0: 16'd248, l7: 16'd255, busy: 1'b0};

    // Reset state
    step(2);
    chk("rst_wr_en", 128'(ifc.wr_en), 128'(0));
    chk("rst_wr_addr", 128'(ifc.wr_addr), 128'(0));
    chk("rst_wr_data", ifc.wr_data, 128'(0));
    chk("rst_rf", 128'(ifc.ram_feedback), 128'(0));
    chk("rst_ovf", 128'(ifc.overflow), 128'(0));
    chk("rst_busy", 128'(ifc.busy), 128'(0));
    rst = 1'b0;
    step(1);

    // Single sample, table of per-cycle expectations after the sample edge
    do_sample(0);
    cur = 0;
    for (int v = 0; v < 6; v++) begin
      step(vt[v].cyc - cur);
      cur = vt[v].cyc;
      chk($sformatf("t1_en[%0d]", vt[v].cyc), 128'(ifc.wr_en), 128'(vt[v].en));
      chk($sformatf("t1_addr[%0d]", vt[v].cyc), 128'(ifc.wr_addr), 128'(vt[v].addr));
      chk($sformatf("t1_l0[%0d]", vt[v].cyc), 128'(ifc.wr_data[15:0]), 128'(vt[v].l0));
      chk($sformatf("t1_l7[%0d]", vt[v].cyc), 128'(ifc.wr_data[127:112]), 128'(vt[v].l7));
      chk($sformatf("t1_busy[%0d]", vt[v].cyc), 128'(ifc.busy), 128'(vt[v].busy));
    end
    step(3);
    chk("t1_count", 128'(n_writes), 128'(32));

    // Back-to-back positions at exactly GROUPS spacing: no bubble
    do_reset();
    cnt = 0;
    for (int c = 0; c <= 320; c++) begin
      if (c % 32 == 0 && c < 320) begin
        set_ofm(c / 32);
        ifc.sample = 1'b1;
      end else begin
        ifc.sample = 1'b0;
      end
      step(1);
      if (c >= 1 && ifc.wr_en === 1'b1) cnt++;
    end
    ifc.sample = 1'b0;
    chk("t3_en_cycles", 128'(cnt), 128'(320));
    step(2);
    chk("t3_count", 128'(n_writes), 128'(320));
    chk("t3_wr_en_off", 128'(ifc.wr_en), 128'(0));
    chk("t3_ovf", 128'(ifc.overflow), 128'(0));

    // Three consecutive samples: third is dropped
    do_reset();
    do_sample(0);
    chk("t4_ovf0", 128'(ifc.overflow), 128'(0));
    do_sample(1);
    chk("t4_ovf1", 128'(ifc.overflow), 128'(0));
    do_sample(77);
    chk("t4_ovf2", 128'(ifc.overflow), 128'(1));
    wait_idle();
    chk("t4_count_a", 128'(n_writes), 128'(64));
    do_sample(2);
    wait_idle();
    chk("t4_count_b", 128'(n_writes), 128'(96));
    chk("t4_ovf_sticky", 128'(ifc.overflow), 128'(1));

    // Asynchronous reset at group 10 of position 3
    do_reset();
    for (int p = 0; p < 4; p++) begin
      do_sample(p);
      if (p < 3) step(39);
    end
    step(11);
    chk("t6_pre_addr", 128'(ifc.wr_addr), 128'(3 * 32 + 10));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_wr_en", 128'(ifc.wr_en), 128'(0));
    chk("t6_wr_addr", 128'(ifc.wr_addr), 128'(0));
    chk("t6_wr_data", ifc.wr_data, 128'(0));
    chk("t6_busy", 128'(ifc.busy), 128'(0));
    chk("t6_ovf", 128'(ifc.overflow), 128'(0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_addr = 0;
    n_writes = 0;
    step(5);
    chk("t6_quiet", 128'(ifc.wr_en), 128'(0));
    do_sample(0);
    step(40);
    chk("t6_count", 128'(n_writes), 128'(32));

    // Full layer at 65-cycle spacing
    do_reset();
    for (int p = 0; p < NPOS; p++) begin
      do_sample(p);
      if (p < NPOS - 1) step(64);
    end
    for (int k = 0; k < 100 && n_writes < NWR; k++) step(1);
    chk("t2_count", 128'(n_writes), 128'(NWR));
    chk("t2_rf", 128'(ifc.ram_feedback), 128'(1));
    chk("t2_wr_en", 128'(ifc.wr_en), 128'(0));
    chk("t2_ovf", 128'(ifc.overflow), 128'(0));
    chk("t2_busy", 128'(ifc.busy), 128'(0));

    // Trailing strobe after the last position
    do_sample(NPOS);
    step(40);
    chk("t5_count", 128'(n_writes), 128'(NWR));
    chk("t5_ovf", 128'(ifc.overflow), 128'(0));
    chk("t5_rf", 128'(ifc.ram_feedback), 128'(1));
    chk("t5_wr_en", 128'(ifc.wr_en), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
